// File: rtl/seg_pkg.sv
// seg_pkg: active-low seven-segment codes shared by the scan driver.
// Bit order is {g,f,e,d,c,b,a}; a 0 lights a segment.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b1000000;
  localparam seg_t SEG_1   = 7'b1111001;
  localparam seg_t SEG_2   = 7'b0100100;
  localparam seg_t SEG_3   = 7'b0110000;
  localparam seg_t SEG_4   = 7'b0011001;
  localparam seg_t SEG_5   = 7'b0010010;
  localparam seg_t SEG_6   = 7'b0000010;
  localparam seg_t SEG_7   = 7'b1111000;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0010000;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b0000011;
  localparam seg_t SEG_C   = 7'b1000110;
  localparam seg_t SEG_D   = 7'b0100001;
  localparam seg_t SEG_E   = 7'b0000110;
  localparam seg_t SEG_F   = 7'b0001110;
  localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit value to active-low gfedcba code.
// Purely combinational; full 0-F hex set.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output seg_t       code
);

  // Hex lookup
  always_comb begin
    code = SEG_OFF;
    unique case (val)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode 7-seg scanner.
// Optional per-digit blink when SEG_BLINK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            val_sel;
  logic                  dp_sel;
  logic                  blank_sel;
  logic                  blink_sel;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  dark;
  seg_t                  code;

  assign tick    = (pre == PRE_MAX);
  assign wrap    = (idx == IDX_MAX);
  assign idx_nxt = wrap ? '0 : idx + 1'b1;

  // Pick the inputs for the digit about to be shown
  always_comb begin
    val_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    an_sel    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        val_sel   = digits[4*k +: 4];
        dp_sel    = dp_mask[k];
        blank_sel = blank_mask[k];
        blink_sel = blink_mask[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  seg_hex_decode u_dec (
    .val  (val_sel),
    .code (code)
  );

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt;
  logic          phase;

  // Frame counter; phase flips only at a frame boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (tick && wrap) begin
      if (fcnt == FRM_MAX) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign dark = blank_sel | (phase & blink_sel);
`else
  logic unused_blink;

  assign unused_blink = blink_sel ^ (BLINK_FRAMES == 0);
  assign dark         = blank_sel;
`endif

  // Prescaler, scan index and output registers, all loaded on tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
      idx <= IDX_MAX;
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx <= idx_nxt;
        an  <= dark ? '1 : an_sel;
        seg <= dark ? SEG_OFF : code;
        dp  <= dark ? 1'b1 : ~dp_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of the scan driver.
// Four digits, four cycles per slot, blink every two frames.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_chk;
  int n_err;

  seg_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];
  logic       blk;

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b0;
    digits     = 16'h0000;
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;

    // reset held three cycles
    step(3);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);

    rst    = 1'b1;
    digits = 16'hA5C0;
    step(3);
    chk("rel3_an", an, 4'hF);
    step(1);
    chk("rel4_an", an, 4'hE);
    chk("rel4_seg", seg, 7'h40);
    chk("rel4_dp", dp, 1'b1);

    // hex scan, two frames, every cycle
    exp_an[0] = 4'hE; exp_seg[0] = 7'h40;
    exp_an[1] = 4'hD; exp_seg[1] = 7'h46;
    exp_an[2] = 4'hB; exp_seg[2] = 7'h12;
    exp_an[3] = 4'h7; exp_seg[3] = 7'h08;
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("scan_an f%0d s%0d c%0d", f, s, c),
              an, exp_an[s]);
          chk($sformatf("scan_seg f%0d s%0d c%0d", f, s, c),
              seg, exp_seg[s]);
          step(1);
        end
      end
    end

    // decimal point on digit 2, digit 3 blanked
    dp_mask    = 4'b0100;
    blank_mask = 4'b1000;
    exp_dp[0] = 1'b1;
    exp_dp[1] = 1'b1;
    exp_dp[2] = 1'b0;
    exp_dp[3] = 1'b1;
    exp_an[3] = 4'hF; exp_seg[3] = 7'h7F;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("dpb_an s%0d c%0d", s, c), an, exp_an[s]);
        chk($sformatf("dpb_seg s%0d c%0d", s, c), seg, exp_seg[s]);
        chk($sformatf("dpb_dp s%0d c%0d", s, c), dp, exp_dp[s]);
        step(1);
      end
    end
    chk("dpb_period_an", an, 4'hE);

    // change digit 0 at pre=1; seg must hold until next visit
    step(1);
    digits = 16'hA5C8;
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("mid_hold c%0d", c), seg, 7'h40);
      step(1);
    end
    chk("mid_s1_an", an, 4'hD);
    chk("mid_s1_seg", seg, 7'h46);
    step(12);
    chk("mid_new_an", an, 4'hE);
    chk("mid_new_seg", seg, 7'h00);

    // reset in the middle of slot 1
    step(6);
    rst        = 1'b0;
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    blink_mask = 4'b0001;
    step(1);
    chk("mrst_an", an, 4'hF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_dp", dp, 1'b1);
    step(1);
    rst = 1'b1;
    step(3);
    chk("mrel3_an", an, 4'hF);
    step(1);

    // blink on digit 0 across five frames
    for (int f = 0; f < 5; f++) begin
`ifdef SEG_BLINK_EN
      blk = (f == 2) || (f == 3);
`else
      blk = 1'b0;
`endif
      chk($sformatf("blink_an f%0d", f), an, blk ? 4'hF : 4'hE);
      chk($sformatf("blink_seg f%0d", f), seg, blk ? 7'h7F : 7'h00);
      chk($sformatf("blink_dp f%0d", f), dp, 1'b1);
      step(4);
      chk($sformatf("blink_s1_an f%0d", f), an, 4'hD);
      chk($sformatf("blink_s1_seg f%0d", f), seg, 7'h46);
      step(12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
